// File: rtl/exec_mon_pkg.sv
// exec_mon_pkg: shared FSM state encoding and status codes for exec_monitor
package exec_mon_pkg;
    typedef enum logic [2:0] {ST_HOLD, ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;
    localparam logic [1:0] STAT_RUN     = 2'b00;
    localparam logic [1:0] STAT_PASS    = 2'b01;
    localparam logic [1:0] STAT_FAIL    = 2'b10;
    localparam logic [1:0] STAT_TIMEOUT = 2'b11;
    function automatic logic [1:0] status_of(state_t s);
        return s == ST_PASS ? STAT_PASS : s == ST_FAIL ? STAT_FAIL :
               s == ST_TIMEOUT ? STAT_TIMEOUT : STAT_RUN;
    endfunction
endpackage

// File: rtl/mon_counter.sv
// mon_counter: wrapping up-counter with enable and synchronous clear
module mon_counter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/exec_monitor.sv
// exec_monitor: core reset sequencer, run counters, retire trace, tohost end-of-test and watchdog
module exec_monitor
    import exec_mon_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               CNT_W       = 64,
    parameter int               RST_CYCLES  = 4,
    parameter int               WDOG_CYCLES = 1024,
    parameter logic [XLEN-1:0]  TOHOST_ADDR = 32'h0000_1000,
    parameter logic [XLEN-1:0]  PC_OFFSET   = 32'h0001_00B0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    input  logic             store_valid,
    input  logic [XLEN-1:0]  store_addr,
    input  logic [XLEN-1:0]  store_data,
    output logic             core_rst_n,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [XLEN-1:0]  trace_pc,
    output logic             done,
    output logic [1:0]       status,
    output logic [XLEN-2:0]  fail_code
);
    localparam int HOLD_W = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYCLES);

    state_t            state, state_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WDOG_W-1:0] wdog_cnt, wdog_nx;
    logic              run, retire, tohost;

    always_comb begin
        run     = state == ST_RUN;
        retire  = run && retire_valid;
        // even-valued tohost writes are console traffic and never terminate
        tohost  = run && store_valid && store_addr == TOHOST_ADDR && store_data[0];
        wdog_nx = retire ? '0 : wdog_cnt + WDOG_W'(1);
        state_n = (state == ST_HOLD && hold_cnt == HOLD_LAST) ? ST_RUN :
                  tohost ? (store_data == XLEN'(1) ? ST_PASS : ST_FAIL) :
                  (run && wdog_nx == WDOG_MAX) ? ST_TIMEOUT : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_HOLD;
        else state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst_n <= 1'b0;
            hold_cnt   <= '0;
            wdog_cnt   <= '0;
            trace_pc   <= '0;
            fail_code  <= '0;
        end else begin
            core_rst_n <= state_n != ST_HOLD;
            if (state == ST_HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
            if (run) wdog_cnt <= wdog_nx;
            if (retire) trace_pc <= retire_pc + PC_OFFSET;
            if (tohost && store_data != XLEN'(1)) fail_code <= store_data[XLEN-1:1];
        end
    end

    mon_counter #(.W(CNT_W)) u_cycle (
        .clk(clk), .rst_n(rst_n), .en(run), .clr(state == ST_HOLD), .cnt(cycle_cnt)
    );

    mon_counter #(.W(CNT_W)) u_instret (
        .clk(clk), .rst_n(rst_n), .en(retire), .clr(state == ST_HOLD), .cnt(instret_cnt)
    );

    assign status = status_of(state);
    assign done   = status != STAT_RUN;
endmodule

// File: tb/tb_exec_monitor.sv
// tb_exec_monitor: directed stimulus with a terminal-event scoreboard for exec_monitor
module tb_exec_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] retire_pc = '0;
    logic        store_valid = 1'b0;
    logic [31:0] store_addr = '0;
    logic [31:0] store_data = '0;
    logic        core_rst_n;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
    logic [31:0] trace_pc;
    logic        done;
    logic [1:0]  status;
    logic [30:0] fail_code;

    typedef struct {
        logic [1:0]  status;
        logic [30:0] fail;
        logic [63:0] cyc;
        logic [63:0] ins;
        logic [31:0] trace;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    logic done_q = 1'b0;

    always #5 clk = ~clk;

    exec_monitor #(
        .XLEN(32), .CNT_W(64), .RST_CYCLES(4), .WDOG_CYCLES(8),
        .TOHOST_ADDR(32'h0000_1000), .PC_OFFSET(32'h0001_00B0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .store_valid(store_valid), .store_addr(store_addr), .store_data(store_data),
        .core_rst_n(core_rst_n), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
        .trace_pc(trace_pc), .done(done), .status(status), .fail_code(fail_code)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] st, input logic [30:0] fc, input logic [63:0] cyc,
                        input logic [63:0] ins, input logic [31:0] tr);
        exp_t x;
        x.status = st; x.fail = fc; x.cyc = cyc; x.ins = ins; x.trace = tr;
        q.push_back(x);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        store_valid = 1'b1;
        store_addr  = a;
        store_data  = d;
    endtask

    always @(posedge clk) begin
        #2;
        if (done && !done_q) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got status %0h expected no terminal event", status);
            end else begin
                e = q.pop_front();
                chk("term_status", 64'(status), 64'(e.status));
                chk("term_fail_code", 64'(fail_code), 64'(e.fail));
                chk("term_cycle_cnt", cycle_cnt, e.cyc);
                chk("term_instret_cnt", instret_cnt, e.ins);
                chk("term_trace_pc", 64'(trace_pc), 64'(e.trace));
            end
        end
        done_q = done;
    end

    initial begin
        #3;
        chk("rst_core_rst_n", 64'(core_rst_n), 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);
        chk("rst_instret_cnt", instret_cnt, 0);
        chk("rst_trace_pc", 64'(trace_pc), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_status", 64'(status), 0);
        chk("rst_fail_code", 64'(fail_code), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("hold_core_rst_n", 64'(core_rst_n), 64'(i == 4));
        end
        chk("cycle_start", cycle_cnt, 0);
        tick();
        chk("cycle_first", cycle_cnt, 1);
        for (int i = 0; i < 10; i++) begin
            retire_valid = 1'b1;
            retire_pc    = 32'h20 + 32'((9 - i) * 16);
            tick();
        end
        retire_valid = 1'b0;
        chk("instret_10", instret_cnt, 10);
        chk("trace_pc_10", 64'(trace_pc), 64'h0001_00D0);
        chk("cycle_11", cycle_cnt, 11);
        store(32'h1000, 32'h4);
        tick();
        chk("console_ignored", 64'(done), 0);
        store(32'h1004, 32'h1);
        tick();
        chk("other_addr_ignored", 64'(done), 0);
        store(32'h1000, 32'h1);
        retire_valid = 1'b1;
        retire_pc    = 32'h40;
        push(2'b01, 31'd0, 64'd14, 64'd11, 32'h0001_00F0);
        tick();
        store_valid = 1'b0;
        repeat (3) tick();
        retire_valid = 1'b0;
        repeat (10) tick();
        chk("pass_instret_frozen", instret_cnt, 11);
        chk("pass_cycle_frozen", cycle_cnt, 14);
        chk("pass_sticky", 64'(status), 64'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("async_core_rst_n", 64'(core_rst_n), 0);
        chk("async_done", 64'(done), 0);
        chk("async_status", 64'(status), 0);
        chk("async_instret", instret_cnt, 0);
        chk("async_trace_pc", 64'(trace_pc), 0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        store(32'h1000, 32'h4);
        tick();
        store(32'h1000, 32'h7);
        push(2'b10, 31'd3, 64'd2, 64'd0, 32'h0);
        tick();
        store_valid = 1'b0;
        tick();
        chk("fail_code_3", 64'(fail_code), 3);
        do_reset();
        repeat (7) tick();
        chk("wdog_not_yet", 64'(done), 0);
        push(2'b11, 31'd0, 64'd8, 64'd0, 32'h0);
        tick();
        repeat (3) tick();
        chk("timeout_sticky", 64'(status), 64'b11);
        do_reset();
        repeat (7) tick();
        store(32'h1000, 32'h1);
        push(2'b01, 31'd0, 64'd8, 64'd0, 32'h0);
        tick();
        store_valid = 1'b0;
        repeat (3) tick();
        chk("tohost_beats_wdog", 64'(status), 64'b01);
        do_reset();
        retire_valid = 1'b1;
        retire_pc    = 32'h0;
        repeat (50) tick();
        chk("run_cycle_50", cycle_cnt, 50);
        chk("run_instret_50", instret_cnt, 50);
        chk("run_trace_pc", 64'(trace_pc), 64'h0001_00B0);
        retire_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_cycle", cycle_cnt, 0);
        chk("midrun_instret", instret_cnt, 0);
        chk("midrun_trace_pc", 64'(trace_pc), 0);
        chk("midrun_core_rst_n", 64'(core_rst_n), 0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rehold_core_rst_n_low", 64'(core_rst_n), 0);
        tick();
        chk("rehold_core_rst_n_high", 64'(core_rst_n), 1);
        chk("rehold_cycle", cycle_cnt, 0);
        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/exec_monitor.md
EXEC_MONITOR -- requirements
Module: exec_monitor

Interface
REQ-001 Parameter XLEN, default 32, address/data/PC width.
REQ-002 Parameter CNT_W, default 64, width of cycle and retire counters.
REQ-003 Parameter RST_CYCLES, default 4, core reset hold length in clk cycles (>=1).
REQ-004 Parameter WDOG_CYCLES, default 1024, max cycles without a retire before timeout (>=2).
REQ-005 Parameter TOHOST_ADDR, default 32'h0000_1000, end-of-test mailbox address.
REQ-006 Parameter PC_OFFSET, default 32'h0001_00B0, load offset added to reported retire PC.
REQ-007 The block SHALL have one clock and an asynchronous active-low reset: clk in 1, clock; rst_n in 1, asynchronous active-low reset.
REQ-008 retire_valid in 1, one instruction retired at writeback this cycle.
REQ-009 retire_pc in XLEN, PC of the retiring instruction (link-relative).
REQ-010 store_valid in 1, data-memory store issued this cycle.
REQ-011 store_addr in XLEN; store_data in XLEN, store address/data.
REQ-012 core_rst_n out 1, sequenced active-low reset to the core.
REQ-013 cycle_cnt out CNT_W; instret_cnt out CNT_W, run-time counters.
REQ-014 trace_pc out XLEN, last retired PC plus PC_OFFSET.
REQ-015 done out 1; status out 2 (00 running, 01 pass, 10 fail, 11 timeout); fail_code out XLEN-1.

Function
REQ-016 FSM states HOLD, RUN, PASS, FAIL, TIMEOUT; reset enters HOLD.
REQ-017 HOLD: core_rst_n=0; hold counter increments each cycle; after RST_CYCLES cycles in HOLD, next state RUN and core_rst_n=1 (registered, rises on that same edge).
REQ-018 RUN: cycle_cnt +1 every cycle; instret_cnt +1 on each cycle with retire_valid; both wrap modulo 2^CNT_W.
REQ-019 retire_valid and store inputs SHALL be ignored outside RUN.
REQ-020 On retire_valid in RUN, trace_pc <= (retire_pc + PC_OFFSET) mod 2^XLEN, one-cycle latency; otherwise holds.
REQ-021 Watchdog counter clears on retire_valid, else +1 in RUN; reaching WDOG_CYCLES -> TIMEOUT.
REQ-022 Tohost store (store_valid && store_addr==TOHOST_ADDR) with store_data==1 -> PASS.
REQ-023 Tohost store with store_data[0]==1 and store_data!=1 -> FAIL, fail_code <= store_data[XLEN-1:1].
REQ-024 Tohost store with store_data[0]==0 SHALL be ignored (console traffic).
REQ-025 Same-cycle tohost terminate and watchdog expiry: tohost wins.
REQ-026 Same-cycle retire and terminating store: retire is counted and traced.
REQ-027 PASS/FAIL/TIMEOUT are sticky until rst_n; counters, trace_pc, fail_code frozen; core_rst_n stays 1.
REQ-028 done=1 and status nonzero exactly when in a terminal state (registered, cycle after the triggering event).

Reset
REQ-029 Asserting rst_n at any time, including mid-run or terminal, SHALL immediately force HOLD, core_rst_n=0, cycle_cnt=0, instret_cnt=0, trace_pc=0, fail_code=0, done=0, status=00, hold/watchdog counters=0.

Structure
REQ-030 FSM state encoding and status codes SHALL live in shared package exec_mon_pkg.
REQ-031 cycle_cnt and instret_cnt SHALL use one sub-module mon_counter (CNT_W, enable, clear, wrap), instantiated twice.

Verification
REQ-032 Reset release, RST_CYCLES=4 -> core_rst_n rises after exactly 4 clk edges; cycle_cnt starts from 0 the next cycle.
REQ-033 10 retires, retire_pc=0x20 last -> instret_cnt=10, trace_pc=0x0001_00D0.
REQ-034 Store 0x1 to 0x1000 -> status=01, done=1 next cycle; further retires leave instret_cnt unchanged.
REQ-035 Store 0x7 to 0x1000 -> status=10, fail_code=3; store 0x4 to 0x1000 earlier -> no effect.
REQ-036 WDOG_CYCLES=8, no retires -> status=11 after 8 RUN cycles; tohost pass on expiry cycle -> status=01.
REQ-037 rst_n asserted mid-RUN with cycle_cnt=50 -> all outputs to reset values asynchronously; full HOLD sequence repeats.
